// File: rtl/fft512_twiddle_sequencer.sv
// Address and twiddle sequencer for a 512-point radix-2 DIT FFT.
// Walks LOG2N stages of 2^(LOG2N-1) butterflies under valid/ready backpressure.
module fft512_twiddle_sequencer #(
   parameter int LOG2N   = 9,
   parameter int ADDR_W  = 10,
   parameter int LUT_LAT = 1
) (
   input  logic              Clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic              bf_ready,
   output logic              busy,
   output logic              done,
   output logic              bf_valid,
   output logic [3:0]        stage,
   output logic [LOG2N-1:0]  addr_top,
   output logic [LOG2N-1:0]  addr_bot,
   output logic [ADDR_W-1:0] addr,
   output logic              tw_valid,
   output logic              tw_last
);

   localparam int BW = LOG2N - 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             r_state;
   state_t             w_stateNext;
   logic [3:0]         r_stage;
   logic [3:0]         w_stageNext;
   logic [BW-1:0]      r_b;
   logic [BW-1:0]      w_bNext;
   logic [LOG2N-1:0]   r_addrTop;
   logic [LOG2N-1:0]   r_addrBot;
   logic [ADDR_W-1:0]  r_addr;
   logic [LUT_LAT-1:0] r_twPipe;
   logic [LUT_LAT-1:0] r_lastPipe;
   logic               w_fire;
   logic               w_lastFire;
   logic               w_abort;

   function automatic logic [LOG2N-1:0] calcTop(input logic [3:0] s, input logic [BW-1:0] b);
      logic [LOG2N-1:0] bx;
      logic [LOG2N-1:0] mask;
      bx   = LOG2N'(b);
      mask = (LOG2N'(1) << s) - LOG2N'(1);
      return ((bx >> s) << (s + 4'd1)) | (bx & mask);
   endfunction

   function automatic logic [LOG2N-1:0] calcBot(input logic [3:0] s, input logic [BW-1:0] b);
      return calcTop(s, b) | (LOG2N'(1) << s);
   endfunction

   function automatic logic [ADDR_W-1:0] calcTw(input logic [3:0] s, input logic [BW-1:0] b);
      logic [LOG2N-1:0]  mask;
      logic [ADDR_W-1:0] jw;
      mask = (LOG2N'(1) << s) - LOG2N'(1);
      jw   = ADDR_W'(LOG2N'(b) & mask);
      return jw << (4'(LOG2N - 1) - s);
   endfunction

   // An abort cancels any handshake in the same cycle so nothing is counted or piped.
   assign w_fire     = (r_state == RUN) && bf_ready && !abort;
   assign w_lastFire = w_fire && (r_stage == 4'(LOG2N - 1)) && (&r_b);
   assign w_abort    = abort && (r_state != IDLE);

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE: if (start) w_stateNext = RUN;
         RUN: begin
            if (abort) begin
               w_stateNext = IDLE;
            end else if (w_lastFire) begin
               w_stateNext = DONE;
            end
         end
         DONE:    w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   always_comb begin
      w_bNext     = r_b + BW'(1);
      w_stageNext = (&r_b) ? r_stage + 4'd1 : r_stage;
   end

   // Addresses are loaded from the next counter values so they line up with bf_valid.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stage   <= '0;
         r_b       <= '0;
         r_addrTop <= '0;
         r_addrBot <= '0;
         r_addr    <= '0;
      end else if (w_abort) begin
         r_stage <= '0;
         r_b     <= '0;
      end else if ((r_state == IDLE) && start) begin
         r_stage   <= '0;
         r_b       <= '0;
         r_addrTop <= calcTop(4'd0, '0);
         r_addrBot <= calcBot(4'd0, '0);
         r_addr    <= calcTw(4'd0, '0);
      end else if (w_lastFire) begin
         r_stage <= '0;
         r_b     <= '0;
      end else if (w_fire) begin
         r_stage   <= w_stageNext;
         r_b       <= w_bNext;
         r_addrTop <= calcTop(w_stageNext, w_bNext);
         r_addrBot <= calcBot(w_stageNext, w_bNext);
         r_addr    <= calcTw(w_stageNext, w_bNext);
      end
   end

   // The delay pipe keeps shifting outside RUN so the final twiddle flag drains after done.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         r_twPipe   <= '0;
         r_lastPipe <= '0;
      end else if (w_abort) begin
         r_twPipe   <= '0;
         r_lastPipe <= '0;
      end else begin
         r_twPipe   <= LUT_LAT'({r_twPipe, w_fire});
         r_lastPipe <= LUT_LAT'({r_lastPipe, w_lastFire});
      end
   end

   assign busy     = (r_state == RUN);
   assign bf_valid = (r_state == RUN);
   assign done     = (r_state == DONE);
   assign stage    = r_stage;
   assign addr_top = r_addrTop;
   assign addr_bot = r_addrBot;
   assign addr     = r_addr;
   assign tw_valid = r_twPipe[LUT_LAT-1];
   assign tw_last  = r_lastPipe[LUT_LAT-1];

endmodule

// File: tb/tb_fft512_twiddle_sequencer.sv
// Scoreboard bench for fft512_twiddle_sequencer: expected butterflies are queued at
// start and a negedge monitor compares every presented butterfly and twiddle flag.
module tb_fft512_twiddle_sequencer;

   localparam int LOG2N   = 9;
   localparam int ADDR_W  = 10;
   localparam int LUT_LAT = 1;
   localparam int NBF     = 256;
   localparam int TOTAL   = 2304;

   logic              Clk;
   logic              reset_n;
   logic              start;
   logic              abort;
   logic              bf_ready;
   logic              busy;
   logic              done;
   logic              bf_valid;
   logic [3:0]        stage;
   logic [LOG2N-1:0]  addr_top;
   logic [LOG2N-1:0]  addr_bot;
   logic [ADDR_W-1:0] addr;
   logic              tw_valid;
   logic              tw_last;

   fft512_twiddle_sequencer #(.LOG2N(LOG2N), .ADDR_W(ADDR_W), .LUT_LAT(LUT_LAT)) dut (
      .Clk(Clk), .reset_n(reset_n), .start(start), .abort(abort), .bf_ready(bf_ready),
      .busy(busy), .done(done), .bf_valid(bf_valid), .stage(stage),
      .addr_top(addr_top), .addr_bot(addr_bot), .addr(addr),
      .tw_valid(tw_valid), .tw_last(tw_last)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [3:0]        s;
      logic [LOG2N-1:0]  top;
      logic [LOG2N-1:0]  bot;
      logic [ADDR_W-1:0] tw;
      logic              last;
   } bfExp_t;

   bfExp_t             sbQ[$];
   int                 checks = 0;
   int                 errors = 0;
   int                 fireIdx = 0;
   int                 twCount = 0;
   int                 twLastCount = 0;
   int                 doneCount = 0;
   logic [LUT_LAT-1:0] fireHist = '0;
   logic [LUT_LAT-1:0] lastHist = '0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic ab, input logic rdy);
      start    = st;
      abort    = ab;
      bf_ready = rdy;
   endtask

   // Expected order built group-by-group: top = g*2m + j, bot = top + m, twiddle = j*(N/2)/m.
   task automatic pushExpected();
      bfExp_t e;
      int m;
      for (int s = 0; s < LOG2N; s++) begin
         m = 1 << s;
         for (int g = 0; g < NBF / m; g++) begin
            for (int j = 0; j < m; j++) begin
               e.s    = 4'(s);
               e.top  = LOG2N'(g * 2 * m + j);
               e.bot  = LOG2N'(g * 2 * m + j + m);
               e.tw   = ADDR_W'(j * (NBF / m));
               e.last = (s == LOG2N - 1) && (g == NBF / m - 1) && (j == m - 1);
               sbQ.push_back(e);
            end
         end
      end
   endtask

   // Monitor: compares the queue head whenever bf_valid is up and pops it on a handshake.
   always @(negedge Clk) begin : monitor
      bfExp_t e;
      logic   fire;
      logic   lastF;
      if (!reset_n) begin
         fireHist = '0;
         lastHist = '0;
      end else begin
         checkOutput("tw_valid", tw_valid, fireHist[LUT_LAT-1]);
         checkOutput("tw_last", tw_last, lastHist[LUT_LAT-1]);
         if (tw_valid) twCount++;
         if (tw_last) twLastCount++;
         if (done) doneCount++;
         fire  = bf_valid && bf_ready;
         lastF = 1'b0;
         if (bf_valid) begin
            if (sbQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_bf actual=stage%0d/top%0d required=no butterfly", stage, addr_top);
            end else begin
               e = sbQ[0];
               checkOutput("bf_stage", stage, e.s);
               checkOutput("bf_addr_top", addr_top, e.top);
               checkOutput("bf_addr_bot", addr_bot, e.bot);
               checkOutput("bf_addr_tw", addr, e.tw);
               if (fire) begin
                  if (fireIdx == 5) begin
                     checkOutput("spot_s0b5_top", addr_top, 10);
                     checkOutput("spot_s0b5_bot", addr_bot, 11);
                     checkOutput("spot_s0b5_tw", addr, 0);
                  end
                  if (fireIdx == 3 * 256 + 13) begin
                     checkOutput("spot_s3b13_top", addr_top, 21);
                     checkOutput("spot_s3b13_bot", addr_bot, 29);
                     checkOutput("spot_s3b13_tw", addr, 160);
                  end
                  if (fireIdx == 8 * 256 + 200) begin
                     checkOutput("spot_s8b200_top", addr_top, 200);
                     checkOutput("spot_s8b200_bot", addr_bot, 456);
                     checkOutput("spot_s8b200_tw", addr, 200);
                  end
                  lastF = e.last;
                  void'(sbQ.pop_front());
                  fireIdx++;
               end
            end
         end
         for (int i = LUT_LAT - 1; i > 0; i--) begin
            fireHist[i] = fireHist[i-1];
            lastHist[i] = lastHist[i-1];
         end
         fireHist[0] = fire;
         lastHist[0] = lastF;
      end
   end

   // Full transform from IDLE; cycle k is the k-th cycle after the edge that samples start.
   task automatic runFull(input bit toggleReady, input bit pokeStart);
      int k;
      bit doneSeen;
      pushExpected();
      @(posedge Clk);
      #1;
      fireIdx = 0; twCount = 0; twLastCount = 0; doneCount = 0;
      applyStimulus(1'b1, 1'b0, 1'b1);
      @(posedge Clk);
      k = 1;
      doneSeen = 1'b0;
      while (k <= 6000) begin
         #1;
         applyStimulus(pokeStart && ((k >= 100 && k <= 102) || k == TOTAL + 1), 1'b0,
                       toggleReady ? k[0] : 1'b1);
         if (done) begin
            doneSeen = 1'b1;
            break;
         end
         @(posedge Clk);
         k++;
      end
      if (!doneSeen) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout actual=no done required=done within 6000 cycles");
      end
      if (!toggleReady) checkOutput("done_cycle", k, TOTAL + 1);
      checkOutput("done_busy", busy, 0);
      checkOutput("done_bf_valid", bf_valid, 0);
      @(posedge Clk);
      #1;
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("done_pulse_width", done, 0);
      repeat (LUT_LAT + 2) @(posedge Clk);
      #1;
      checkOutput("idle_busy", busy, 0);
      checkOutput("fire_count", fireIdx, TOTAL);
      checkOutput("queue_empty", sbQ.size(), 0);
      checkOutput("tw_valid_count", twCount, TOTAL);
      checkOutput("tw_last_count", twLastCount, 1);
      checkOutput("done_count", doneCount, 1);
   endtask

   // Runs until butterfly `target` is presented, then stalls it with bf_ready low.
   task automatic runPartial(input int target);
      int k;
      pushExpected();
      @(posedge Clk);
      #1;
      fireIdx = 0;
      applyStimulus(1'b1, 1'b0, 1'b1);
      @(posedge Clk);
      #1;
      applyStimulus(1'b0, 1'b0, 1'b1);
      for (k = 0; k < 5000 && fireIdx < target; k++) @(posedge Clk);
      if (fireIdx != target) begin
         checks++;
         errors++;
         $display("[TB] FAIL partial_timeout actual=%0d required=%0d", fireIdx, target);
      end
      #1;
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   initial begin : stimulus
      int d0;
      reset_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_bf_valid", bf_valid, 0);
      checkOutput("rst_stage", stage, 0);
      checkOutput("rst_addr_top", addr_top, 0);
      checkOutput("rst_addr_bot", addr_bot, 0);
      checkOutput("rst_addr", addr, 0);
      checkOutput("rst_tw_valid", tw_valid, 0);
      repeat (2) @(posedge Clk);
      #1;
      reset_n = 1'b1;

      runFull(1'b0, 1'b0);
      runFull(1'b1, 1'b0);

      runPartial(4 * 256 + 77);
      checkOutput("hold_s4b77_stage", stage, 4);
      checkOutput("hold_s4b77_top", addr_top, 141);
      checkOutput("hold_s4b77_bot", addr_bot, 157);
      checkOutput("hold_s4b77_tw", addr, 208);
      #1;
      reset_n = 1'b0;
      #1;
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_bf_valid", bf_valid, 0);
      checkOutput("midrst_stage", stage, 0);
      checkOutput("midrst_addr_top", addr_top, 0);
      checkOutput("midrst_addr_bot", addr_bot, 0);
      checkOutput("midrst_addr", addr, 0);
      checkOutput("midrst_tw_valid", tw_valid, 0);
      sbQ.delete();
      @(posedge Clk);
      #1;
      reset_n = 1'b1;
      runFull(1'b0, 1'b1);

      runPartial(2 * 256 + 100);
      checkOutput("hold_s2b100_stage", stage, 2);
      checkOutput("hold_s2b100_top", addr_top, 200);
      checkOutput("hold_s2b100_bot", addr_bot, 204);
      checkOutput("hold_s2b100_tw", addr, 0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      @(posedge Clk);
      #1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_bf_valid", bf_valid, 0);
      checkOutput("abort_stage", stage, 0);
      checkOutput("abort_done", done, 0);
      sbQ.delete();
      d0 = doneCount;
      repeat (5) @(posedge Clk);
      #1;
      checkOutput("abort_no_done", doneCount, d0);
      checkOutput("abort_idle_busy", busy, 0);
      runFull(1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog actual=still running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
